vga_timing_gen: RTL

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_pkg.sv | 31 +++
 rtl/vga_axis_counter.sv | 43 ++++
 rtl/vga_timing_gen.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing defaults, pixel type and bar-pattern helper
package vga_pkg;

  // Default 640x480 @ 60 Hz timing (pixels / lines).
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // Default bits per colour channel.
  localparam int DEF_COLOR_W  = 2;

  // One pixel at the default colour depth, red in the most significant bits.
  typedef struct packed {
    logic [DEF_COLOR_W-1:0] r;
    logic [DEF_COLOR_W-1:0] g;
    logic [DEF_COLOR_W-1:0] b;
  } rgb_t;

  // Index of the vertical colour bar (0..7) that column x falls into.
  function automatic logic [2:0] bar_index(input int x, input int h_active);
    int k;
    k = (x * 8) / h_active;
    return k[2:0];
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one timing axis: counter with wrap, sync window and active flag
module vga_axis_counter #(
  parameter int ACTIVE   = 640,
  parameter int FP       = 16,
  parameter int SYNC     = 96,
  parameter int BP       = 48,
  parameter bit SYNC_POL = 1'b0,
  localparam int TOTAL   = ACTIVE + FP + SYNC + BP,
  localparam int W       = $clog2(TOTAL)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         advance,
  output logic [W-1:0] count,
  output logic         sync,
  output logic         active,
  output logic         wrap
);

  localparam logic [W-1:0] LAST       = W'(TOTAL - 1);
  localparam logic [W-1:0] ACTIVE_END = W'(ACTIVE);
  localparam logic [W-1:0] SYNC_FIRST = W'(ACTIVE + FP);
  localparam logic [W-1:0] SYNC_LAST  = W'(ACTIVE + FP + SYNC - 1);

  // Every timing segment must be at least one unit long.
  if (ACTIVE < 1 || FP < 1 || SYNC < 1 || BP < 1) begin : g_bad_timing
    $error("vga_axis_counter: timing parameters must all be non-zero");
  end

  assign wrap   = advance && (count == LAST);
  assign active = (count < ACTIVE_END);
  assign sync   = ((count >= SYNC_FIRST) && (count <= SYNC_LAST)) ? SYNC_POL : ~SYNC_POL;

  // Position counter: steps on each advance and folds back to zero after the last unit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (advance) begin
      count <= wrap ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator with registered, blanked colour and syncs
// Optional build macro VGA_TEST_PATTERN_EN adds i_test_mode and an 8-bar colour test pattern.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV  = 1,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit SYNC_POL = 1'b0,
  parameter int COLOR_W  = DEF_COLOR_W,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int XW      = $clog2(H_TOTAL),
  localparam int YW      = $clog2(V_TOTAL)
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
`ifdef VGA_TEST_PATTERN_EN
  input  logic                 i_test_mode,
`endif
  input  logic [3*COLOR_W-1:0] i_rgb,
  output logic [XW-1:0]        o_x,
  output logic [YW-1:0]        o_y,
  output logic                 o_active,
  output logic                 o_pix_en,
  output logic                 o_line_start,
  output logic                 o_frame_start,
  output logic [COLOR_W-1:0]   o_vga_r,
  output logic [COLOR_W-1:0]   o_vga_g,
  output logic [COLOR_W-1:0]   o_vga_b,
  output logic                 o_vga_hs,
  output logic                 o_vga_vs
);

  if (CLK_DIV < 1) begin : g_bad_clk_div
    $error("vga_timing_gen: CLK_DIV must be at least 1");
  end

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

  logic [PW-1:0]        presc;
  logic                 pix_en;
  logic [XW-1:0]        h_count;
  logic [YW-1:0]        v_count;
  logic                 h_sync;
  logic                 v_sync;
  logic                 h_active;
  logic                 v_active;
  logic                 h_wrap;
  logic                 v_wrap_unused;
  logic [3*COLOR_W-1:0] act_rgb;
  logic [3*COLOR_W-1:0] rgb_q;
  logic                 hs_q;
  logic                 vs_q;

  // Prescaler: divides the system clock down to the pixel rate.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      presc <= '0;
    end else if (presc == PRESC_LAST) begin
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // With CLK_DIV=1 the prescaler sits at zero and the strobe is permanently high.
  assign pix_en = (presc == PRESC_LAST);

  vga_axis_counter #(
    .ACTIVE   (H_ACTIVE),
    .FP       (H_FP),
    .SYNC     (H_SYNC),
    .BP       (H_BP),
    .SYNC_POL (SYNC_POL)
  ) u_h_axis (
    .clock    (i_clock),
    .reset    (i_reset),
    .advance  (pix_en),
    .count    (h_count),
    .sync     (h_sync),
    .active   (h_active),
    .wrap     (h_wrap)
  );

  // The vertical axis steps once per completed line, wrapping on the same edge as the line.
  vga_axis_counter #(
    .ACTIVE   (V_ACTIVE),
    .FP       (V_FP),
    .SYNC     (V_SYNC),
    .BP       (V_BP),
    .SYNC_POL (SYNC_POL)
  ) u_v_axis (
    .clock    (i_clock),
    .reset    (i_reset),
    .advance  (h_wrap),
    .count    (v_count),
    .sync     (v_sync),
    .active   (v_active),
    .wrap     (v_wrap_unused)
  );

  assign o_x           = h_count;
  assign o_y           = v_count;
  assign o_active      = h_active & v_active;
  assign o_pix_en      = pix_en;
  assign o_line_start  = pix_en & (h_count == '0);
  assign o_frame_start = pix_en & (h_count == '0) & (v_count == '0);

`ifdef VGA_TEST_PATTERN_EN
  logic [2:0] bar;
  assign bar     = bar_index(int'(h_count), H_ACTIVE);
  assign act_rgb = i_test_mode ? {{COLOR_W{bar[2]}}, {COLOR_W{bar[1]}}, {COLOR_W{bar[0]}}}
                               : i_rgb;
`else
  assign act_rgb = i_rgb;
`endif

  // Output stage: capture blanked colour and syncs once per pixel, one pixel behind the counters.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      rgb_q <= '0;
      hs_q  <= ~SYNC_POL;
      vs_q  <= ~SYNC_POL;
    end else if (pix_en) begin
      rgb_q <= o_active ? act_rgb : '0;
      hs_q  <= h_sync;
      vs_q  <= v_sync;
    end
  end

  assign o_vga_r  = rgb_q[3*COLOR_W-1 -: COLOR_W];
  assign o_vga_g  = rgb_q[2*COLOR_W-1 -: COLOR_W];
  assign o_vga_b  = rgb_q[COLOR_W-1:0];
  assign o_vga_hs = hs_q;
  assign o_vga_vs = vs_q;

endmodule
